mult_share_arbiter: RTL and testbench

Shares one 3-stage pipelined 4x4 unsigned multiplier among NUM_REQ requesters.
- Round-robin arbitration issues at most one operand pair per cycle into the multiplier.
- An ID/valid tag pipeline runs alongside the multiplier pipeline.
- Each product is steered into the issuing requester's 1-entry result buffer.
- The block sits between client logic and the multiplier instance. The multiplier itself is not modified and has no reset.

---
 rtl/mult_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/mult_share_arbiter.sv | 130 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and the tag format carried alongside the multiplier pipeline.
package mult_pkg;

   localparam int OP_W    = 4;
   localparam int PROD_W  = 2 * OP_W;
   localparam int MUL_LAT = 3;
   // Wide enough for requester ids up to NUM_REQ = 8
   localparam int ID_W    = 3;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index after rr_ptr, wrapping.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      // The pointer itself is searched last, so the previous winner has lowest priority
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand     = (int'(rr_ptr) + off) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!grant_any && eligible[cand_idx]) begin
            grant_any       = 1'b1;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters; a tag pipeline tracks
// which requester owns each product so it lands in that requester's result buffer.
module mult_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int OP_W    = 4,
   parameter int LAT     = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*OP_W-1:0]     req_x,
   input  logic [NUM_REQ*OP_W-1:0]     req_y,
   output logic [OP_W-1:0]             mul_x,
   output logic [OP_W-1:0]             mul_y,
   input  logic [2*OP_W-1:0]           mul_out,
   output logic [NUM_REQ-1:0]          rsp_valid,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [NUM_REQ*2*OP_W-1:0]   rsp_data,
   output logic [$clog2(LAT+1):0]      inflight
);

   import mult_pkg::tag_t;
   import mult_pkg::ID_W;

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PW    = 2 * OP_W;
   localparam int CNT_W = $clog2(LAT+1) + 1;

   logic [IDX_W-1:0]   rr_ptr_reg;
   logic [NUM_REQ-1:0] outstanding;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] retire_hit;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_any;
   logic [CNT_W-1:0]   inflight_cnt;
   tag_t               tag_reg [LAT];
   tag_t               ret_tag;

   // A requester with an op in flight or an unread result must wait, even if it reads this cycle
   assign eligible = req_valid & ~outstanding & ~rsp_valid;

   rr_arbiter #(
      .NUM_REQ   (NUM_REQ)
   ) u_arb (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign req_ready = grant;
   assign mul_x     = grant_any ? req_x[grant_idx*OP_W +: OP_W] : '0;
   assign mul_y     = grant_any ? req_y[grant_idx*OP_W +: OP_W] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg <= IDX_W'(NUM_REQ-1);
      end else if (grant_any) begin
         rr_ptr_reg <= grant_idx;
      end
   end

   // Tag stage LAT-1 lines up with the product currently on mul_out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < LAT; s++) begin
            tag_reg[s] <= '0;
         end
      end else begin
         tag_reg[0].valid <= grant_any;
         tag_reg[0].id    <= ID_W'(grant_idx);
         for (int s = 1; s < LAT; s++) begin
            tag_reg[s] <= tag_reg[s-1];
         end
      end
   end

   assign ret_tag = tag_reg[LAT-1];

   always_comb begin
      inflight_cnt = '0;
      for (int s = 0; s < LAT; s++) begin
         inflight_cnt = inflight_cnt + CNT_W'(tag_reg[s].valid);
      end
   end

   assign inflight = inflight_cnt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         logic          out_reg;
         logic          vld_reg;
         logic [PW-1:0] data_reg;

         assign retire_hit[gi] = ret_tag.valid && (ret_tag.id == ID_W'(gi));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_reg <= 1'b0;
            end else if (grant[gi]) begin
               out_reg <= 1'b1;
            end else if (retire_hit[gi]) begin
               out_reg <= 1'b0;
            end
         end

         // Retire has priority over a consume on the same edge
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_reg  <= 1'b0;
               data_reg <= '0;
            end else if (retire_hit[gi]) begin
               vld_reg  <= 1'b1;
               data_reg <= mul_out;
            end else if (rsp_ready[gi]) begin
               vld_reg  <= 1'b0;
            end
         end

         assign outstanding[gi]           = out_reg;
         assign rsp_valid[gi]             = vld_reg;
         assign rsp_data[gi*PW +: PW]     = data_reg;
      end
   endgenerate

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized and directed checks of mult_share_arbiter against a queue-based model.
module tb_mult_share_arbiter;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int L  = 3;
   localparam int PW = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*W-1:0]    req_x;
   logic [N*W-1:0]    req_y;
   logic [W-1:0]      mul_x;
   logic [W-1:0]      mul_y;
   logic [PW-1:0]     mul_out;
   logic [N-1:0]      rsp_valid;
   logic [N-1:0]      rsp_ready;
   logic [N*PW-1:0]   rsp_data;
   logic [2:0]        inflight;

   always #5 clk = ~clk;

   mult_share_arbiter #(
      .NUM_REQ   (N),
      .OP_W      (W),
      .LAT       (L)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .mul_x     (mul_x),
      .mul_y     (mul_y),
      .mul_out   (mul_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .inflight  (inflight)
   );

   // Stand-in for the shared multiplier: three registers, no reset
   logic [PW-1:0] p1, p2, p3;
   always @(posedge clk) begin
      p1 <= PW'(mul_x) * PW'(mul_y);
      p2 <= p1;
      p3 <= p2;
   end
   assign mul_out = p3;

   typedef struct {
      int            due;
      int            id;
      logic [PW-1:0] p;
   } op_t;

   op_t           pend[$];
   bit            m_out [N];
   bit            m_bv  [N];
   logic [PW-1:0] m_bd  [N];
   int            m_ptr;
   int            cyc;
   int            total = 0;
   int            bad   = 0;
   int            last_grant;
   logic [N-1:0]    s_ready, s_rsp_valid, prev_hold;
   logic [N*PW-1:0] s_rsp_data, prev_data;
   logic [2:0]      s_inflight;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic int exp_winner();
      for (int off = 1; off <= N; off++) begin
         int k;
         k = (m_ptr + off) % N;
         if (req_valid[k] && !m_out[k] && !m_bv[k]) return k;
      end
      return -1;
   endfunction

   task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
      req_x[i*W +: W] = x;
      req_y[i*W +: W] = y;
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst_n     = 1'b0;
      pend.delete();
      for (int k = 0; k < N; k++) begin
         m_out[k] = 1'b0;
         m_bv[k]  = 1'b0;
         m_bd[k]  = '0;
      end
      m_ptr     = N - 1;
      prev_hold = '0;
      @(negedge clk);
      check_val("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check_val("rst_rsp_data", 64'(rsp_data), 64'(0));
      check_val("rst_inflight", 64'(inflight), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Compare all outputs mid-cycle, then advance the model across the next rising edge
   task automatic run_cycle();
      int              g;
      logic [N-1:0]    er, ev;
      logic [W-1:0]    ex, ey;
      logic [N*PW-1:0] ed;
      logic [PW-1:0]   p;
      op_t             o;
      @(negedge clk);
      g  = exp_winner();
      ex = '0;
      ey = '0;
      if (g >= 0) begin
         ex = req_x[g*W +: W];
         ey = req_y[g*W +: W];
      end
      for (int k = 0; k < N; k++) begin
         er[k]            = (k == g);
         ev[k]            = m_bv[k];
         ed[k*PW +: PW]   = m_bd[k];
      end
      check_val("req_ready", 64'(req_ready), 64'(er));
      check_val("mul_x", 64'(mul_x), 64'(ex));
      check_val("mul_y", 64'(mul_y), 64'(ey));
      check_val("rsp_valid", 64'(rsp_valid), 64'(ev));
      check_val("rsp_data", 64'(rsp_data), 64'(ed));
      check_val("inflight", 64'(inflight), 64'(pend.size()));
      for (int k = 0; k < N; k++) begin
         if (prev_hold[k]) begin
            check_val("hold_data", 64'(rsp_data[k*PW +: PW]), 64'(prev_data[k*PW +: PW]));
         end
      end
      prev_hold   = rsp_valid & ~rsp_ready;
      prev_data   = rsp_data;
      s_ready     = req_ready;
      s_rsp_valid = rsp_valid;
      s_rsp_data  = rsp_data;
      s_inflight  = inflight;
      last_grant  = g;
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         if (rsp_ready[k]) m_bv[k] = 1'b0;
      end
      while (pend.size() > 0 && pend[0].due == cyc) begin
         o = pend.pop_front();
         m_bv[o.id]  = 1'b1;
         m_bd[o.id]  = o.p;
         m_out[o.id] = 1'b0;
         $display("rsp req=%0d data=%02h cyc=%0d", o.id, o.p, cyc);
      end
      if (g >= 0) begin
         p        = PW'(ex) * PW'(ey);
         m_out[g] = 1'b1;
         m_ptr    = g;
         pend.push_back('{due: cyc + L, id: g, p: p});
      end
      cyc++;
      #1;
   endtask

   logic [PW-1:0] cont_exp [4];
   int            peak, gcount, first_g;
   int            cnt [N];
   int            sum;

   initial begin
      cyc = 0;
      req_valid = '0; req_x = '0; req_y = '0; rsp_ready = '0;
      do_reset();

      // single op, no contention
      rsp_ready = '1;
      set_op(0, 4'hF, 4'hF);
      req_valid = 4'b0001;
      for (int c = 0; c < 6; c++) begin
         run_cycle();
         req_valid = '0;
         if (c == 0) check_val("single_grant", 64'(s_ready), 64'(4'b0001));
         if (c >= 1 && c <= 3) check_val("single_inflight", 64'(s_inflight), 64'(1));
         if (c == 4) begin
            check_val("single_valid", 64'(s_rsp_valid[0]), 64'(1));
            check_val("single_data", 64'(s_rsp_data[7:0]), 64'(8'hE1));
         end
      end

      // four-way contention from reset
      do_reset();
      set_op(0, 4'h3, 4'h5); set_op(1, 4'h2, 4'h7); set_op(2, 4'hF, 4'h1); set_op(3, 4'h0, 4'h9);
      cont_exp[0] = 8'h0F; cont_exp[1] = 8'h0E; cont_exp[2] = 8'h0F; cont_exp[3] = 8'h00;
      req_valid = 4'b1111;
      peak = 0;
      for (int c = 0; c < 10; c++) begin
         run_cycle();
         if (last_grant >= 0) req_valid[last_grant] = 1'b0;
         if (int'(s_inflight) > peak) peak = int'(s_inflight);
         if (c < 4) check_val("cont_grant", 64'(s_ready), 64'(1 << c));
         if (c >= 4 && c < 8) check_val("cont_data", 64'(s_rsp_data[(c-4)*PW +: PW]), 64'(cont_exp[c-4]));
      end
      check_val("cont_peak", 64'(peak), 64'(3));

      // backpressure on requester 2, then a one-cycle consume pulse
      rsp_ready = 4'b1011;
      req_valid = 4'b1111;
      for (int c = 0; c < 30; c++) begin
         for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
         rsp_ready[2] = (c == 20);
         run_cycle();
      end

      // outstanding block: one requester, consumer always ready
      do_reset();
      rsp_ready = '1;
      set_op(1, 4'hA, 4'hB);
      req_valid = 4'b0010;
      gcount = 0; first_g = -1;
      for (int c = 0; c < 20; c++) begin
         run_cycle();
         if (s_ready[1]) begin
            gcount++;
            if (first_g < 0) first_g = c;
         end
      end
      check_val("block_grants", 64'(gcount), 64'(4));
      check_val("block_first", 64'(first_g), 64'(0));

      // reset while ops are in flight
      do_reset();
      set_op(0, 4'h9, 4'h9); set_op(1, 4'h8, 4'h7); set_op(2, 4'h6, 4'h5);
      req_valid = 4'b0111;
      run_cycle();
      run_cycle();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         run_cycle();
         check_val("midrst_valid", 64'(s_rsp_valid), 64'(0));
         check_val("midrst_inflight", 64'(s_inflight), 64'(0));
      end
      set_op(3, 4'h7, 4'h9);
      req_valid = 4'b1000;
      for (int c = 0; c < 6; c++) begin
         run_cycle();
         req_valid = '0;
         if (c == 4) begin
            check_val("post_rst_valid", 64'(s_rsp_valid[3]), 64'(1));
            check_val("post_rst_data", 64'(s_rsp_data[3*PW +: PW]), 64'(8'h3F));
         end
      end

      // sweep all operand pairs per requester under random traffic
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int c = 0; c < 8000; c++) begin
         sum = 0;
         for (int i = 0; i < N; i++) sum += cnt[i];
         if (sum == N * 256) break;
         for (int i = 0; i < N; i++) begin
            req_valid[i] = (cnt[i] < 256) && ($urandom_range(0, 3) != 0);
            set_op(i, W'(cnt[i] >> 4), W'(cnt[i]));
            rsp_ready[i] = ($urandom_range(0, 2) != 0);
         end
         run_cycle();
         if (last_grant >= 0) cnt[last_grant]++;
      end
      req_valid = '0;
      rsp_ready = '1;
      for (int c = 0; c < 8; c++) run_cycle();
      sum = 0;
      for (int i = 0; i < N; i++) sum += cnt[i];
      check_val("sweep_done", 64'(sum), 64'(N * 256));
      check_val("sweep_drained", 64'(s_inflight), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
